demux_chan_counter: RTL and testbench

Downstream consumer of the 1-to-4 demultiplexer. Takes the four demux outputs and counts rising edges (events) per channel in saturating counters. Records the most recently active channel and flags any cycle where more than one channel is high, which a correct demux never produces. Counts are read back through a registered, address-selected port.

---
 rtl/demux_chan_counter_pkg.sv | 27 ++
 rtl/demux_chan_counter_if.sv | 40 ++++
 rtl/demux_chan_counter_chan_counter.sv | 43 ++++
 rtl/demux_chan_counter.sv | 76 +++++++
 tb/tb_demux_chan_counter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_chan_counter_pkg.sv
// Shared types and helpers for the demux channel event counter.
// Channel count and index width are fixed by the upstream 1-to-4 demux.
package demux_chan_counter_pkg;

  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned CH_IDX_W      = 2;
  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;
  typedef logic [NUM_CH-1:0]   ch_vec_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic ch_idx_t lowest_set(input ch_vec_t v);
    ch_idx_t idx;
    idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (v[i]) idx = ch_idx_t'(i);
    end
    return idx;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input ch_vec_t v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/demux_chan_counter_if.sv
// Signal bundle between the demux-side logic and the channel event counter.
// The master side drives channel levels, clears and readback select.
interface demux_chan_counter_if
  import demux_chan_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) ();

  ch_vec_t          ch_in;
  ch_vec_t          clr;
  ch_idx_t          rd_sel;
  logic [CNT_W-1:0] rd_count;
  ch_vec_t          sat;
  ch_idx_t          last_ch;
  logic             last_valid;
  logic             onehot_err;

  modport master (
    output ch_in,
    output clr,
    output rd_sel,
    input  rd_count,
    input  sat,
    input  last_ch,
    input  last_valid,
    input  onehot_err
  );

  modport slave (
    input  ch_in,
    input  clr,
    input  rd_sel,
    output rd_count,
    output sat,
    output last_ch,
    output last_valid,
    output onehot_err
  );

endinterface

// File: rtl/demux_chan_counter_chan_counter.sv
// One channel: rising-edge detector feeding a saturating event counter.
// Clear has priority over a coincident rise, which is then dropped.
module demux_chan_counter_chan_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o,
  output logic             rise_o
);

  logic             prev_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= in_i;
      count_q <= count_d;
    end
  end

  // prev_q resets low, so a level already high after reset counts as a rise.
  assign rise_o = in_i & ~prev_q;
  assign sat_o  = &count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (rise_o && !sat_o) begin
      count_d = count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/demux_chan_counter.sv
// Per-channel event counters behind a 1-to-4 demux, with registered readback,
// last-active-channel tracking and a sticky flag for multi-hot demux outputs.
module demux_chan_counter
  import demux_chan_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  demux_chan_counter_if.slave bus
);

  logic [CNT_W-1:0] count [NUM_CH];
  ch_vec_t          sat;
  ch_vec_t          rise;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_chan
    demux_chan_counter_chan_counter #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i   (clk),
      .rst_i   (rst),
      .in_i    (bus.ch_in[i]),
      .clr_i   (bus.clr[i]),
      .count_o (count[i]),
      .sat_o   (sat[i]),
      .rise_o  (rise[i])
    );
  end

  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  ch_idx_t          last_ch_q, last_ch_d;
  logic             last_valid_q, last_valid_d;
  logic             onehot_err_q, onehot_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q   <= '0;
      last_ch_q    <= '0;
      last_valid_q <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      rd_count_q   <= rd_count_d;
      last_ch_q    <= last_ch_d;
      last_valid_q <= last_valid_d;
      onehot_err_q <= onehot_err_d;
    end
  end

  always_comb begin
    // Readback samples the counter before this cycle's update.
    rd_count_d   = count[bus.rd_sel];
    last_ch_d    = last_ch_q;
    last_valid_d = last_valid_q;
    onehot_err_d = onehot_err_q;

    if (rise != '0) begin
      last_ch_d    = lowest_set(rise);
      last_valid_d = 1'b1;
    end

    // A fresh multi-hot observation beats a simultaneous global clear.
    if (multi_hot(bus.ch_in)) begin
      onehot_err_d = 1'b1;
    end else if (&bus.clr) begin
      onehot_err_d = 1'b0;
    end
  end

  assign bus.rd_count   = rd_count_q;
  assign bus.sat        = sat;
  assign bus.last_ch    = last_ch_q;
  assign bus.last_valid = last_valid_q;
  assign bus.onehot_err = onehot_err_q;

endmodule

// File: tb/tb_demux_chan_counter.sv
// Bench for demux_chan_counter: an 8-bit and a 2-bit instance share stimulus;
// a reference model feeds a readback scoreboard and per-cycle status checks.
module tb_demux_chan_counter;
  import demux_chan_counter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_chan_counter_if #(.CNT_W(8)) bus8 ();
  demux_chan_counter_if #(.CNT_W(2)) bus2 ();

  assign bus2.ch_in  = bus8.ch_in;
  assign bus2.clr    = bus8.clr;
  assign bus2.rd_sel = bus8.rd_sel;

  demux_chan_counter #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  demux_chan_counter #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] v8;
    logic [1:0] v2;
  } exp_t;
  exp_t sb_q[$];

  int         m8[4];
  int         m2[4];
  logic [3:0] m_prev;
  logic [1:0] m_last;
  logic       m_lv;
  logic       m_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m8[i] = 0;
      m2[i] = 0;
    end
    m_prev = 4'b0;
    m_last = 2'd0;
    m_lv   = 1'b0;
    m_err  = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [3:0] ch, input logic [3:0] c);
    logic [3:0] rise;
    rise = ch & ~m_prev;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) begin
        m8[i] = 0;
        m2[i] = 0;
      end else if (rise[i]) begin
        if (m8[i] < 255) m8[i]++;
        if (m2[i] < 3) m2[i]++;
      end
    end
    if (rise != 4'b0) begin
      m_lv = 1'b1;
      for (int i = 3; i >= 0; i--) if (rise[i]) m_last = 2'(i);
    end
    if ($countones(ch) > 1) m_err = 1'b1;
    else if (c == 4'hF) m_err = 1'b0;
    m_prev = ch;
  endtask

  // Drive one cycle; returns 1 time unit after the active edge.
  task automatic step(input logic [3:0] ch, input logic [3:0] c, input logic [1:0] sel);
    exp_t e;
    @(negedge clk);
    bus8.ch_in  = ch;
    bus8.clr    = c;
    bus8.rd_sel = sel;
    e.v8 = 8'(m8[sel]);
    e.v2 = 2'(m2[sel]);
    sb_q.push_back(e);
    model_step(ch, c);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: readback against queued values, status against the model.
  always begin
    exp_t       e;
    logic [3:0] es8, es2;
    @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus8.rd_count !== e.v8 || bus2.rd_count !== e.v2) begin
        errors++;
        $display("FAIL sb_rd_count got %0d/%0d want %0d/%0d at %0t",
                 bus8.rd_count, bus2.rd_count, e.v8, e.v2, $time);
      end
    end
    for (int i = 0; i < 4; i++) begin
      es8[i] = (m8[i] == 255);
      es2[i] = (m2[i] == 3);
    end
    checks++;
    if (bus8.sat !== es8 || bus2.sat !== es2) begin
      errors++;
      $display("FAIL sb_sat got %b/%b want %b/%b at %0t", bus8.sat, bus2.sat, es8, es2, $time);
    end
    checks++;
    if (bus8.last_valid !== m_lv || bus8.onehot_err !== m_err ||
        bus2.last_valid !== m_lv || bus2.onehot_err !== m_err) begin
      errors++;
      $display("FAIL sb_flags got lv=%b err=%b want lv=%b err=%b at %0t",
               bus8.last_valid, bus8.onehot_err, m_lv, m_err, $time);
    end
    if (m_lv) begin
      checks++;
      if (bus8.last_ch !== m_last || bus2.last_ch !== m_last) begin
        errors++;
        $display("FAIL sb_last_ch got %0d want %0d at %0t", bus8.last_ch, m_last, $time);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus8.ch_in  = 4'b0;
    bus8.clr    = 4'b0;
    bus8.rd_sel = 2'd0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0, 4'b0, 2'(i % 4));
      checks++;
      if (bus8.rd_count !== 8'd0 || bus8.sat !== 4'b0 || bus8.last_valid !== 1'b0 ||
          bus8.onehot_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got rd=%0d sat=%b lv=%b err=%b want 0/0000/0/0",
                 bus8.rd_count, bus8.sat, bus8.last_valid, bus8.onehot_err);
      end
    end
  endtask

  task automatic test_counting();
    logic [7:0] want[4];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 4'b0, 2'd0);
      step(4'b0000, 4'b0, 2'd0);
    end
    for (int i = 0; i < 5; i++) step(4'b0010, 4'b0, 2'd0);
    step(4'b0000, 4'b0, 2'd0);
    checks++;
    if (bus8.last_ch !== 2'd1 || bus8.last_valid !== 1'b1) begin
      errors++;
      $display("FAIL count_last got ch=%0d lv=%b want 1/1", bus8.last_ch, bus8.last_valid);
    end
    want[0] = 8'd0; want[1] = 8'd1; want[2] = 8'd3; want[3] = 8'd0;
    for (int s = 3; s >= 0; s--) begin
      step(4'b0, 4'b0, 2'(s));
      checks++;
      if (bus8.rd_count !== want[s]) begin
        errors++;
        $display("FAIL count_rd ch%0d got %0d want %0d", s, bus8.rd_count, want[s]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 4'b0, 2'd0);
      step(4'b0000, 4'b0, 2'd0);
    end
    checks++;
    if (bus2.rd_count !== 2'd3 || bus2.sat !== 4'b0001 || bus8.rd_count !== 8'd5) begin
      errors++;
      $display("FAIL sat_hold got rd2=%0d sat2=%b rd8=%0d want 3/0001/5",
               bus2.rd_count, bus2.sat, bus8.rd_count);
    end
    step(4'b0000, 4'b0001, 2'd0);
    checks++;
    if (bus2.sat !== 4'b0000) begin
      errors++;
      $display("FAIL sat_clr got sat2=%b want 0000", bus2.sat);
    end
    step(4'b0000, 4'b0000, 2'd0);
    checks++;
    if (bus2.rd_count !== 2'd0 || bus8.rd_count !== 8'd0) begin
      errors++;
      $display("FAIL sat_clr_rd got %0d/%0d want 0/0", bus2.rd_count, bus8.rd_count);
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'b1000, 4'b0, 2'd3);
      step(4'b0000, 4'b0, 2'd3);
    end
    step(4'b1000, 4'b1000, 2'd3);
    checks++;
    if (bus8.rd_count !== 8'd2 || bus8.last_ch !== 2'd3) begin
      errors++;
      $display("FAIL coll_pre got rd=%0d last=%0d want 2/3", bus8.rd_count, bus8.last_ch);
    end
    step(4'b0000, 4'b0000, 2'd3);
    checks++;
    if (bus8.rd_count !== 8'd0) begin
      errors++;
      $display("FAIL coll_clr_wins got %0d want 0", bus8.rd_count);
    end
  endtask

  task automatic test_demux_fault();
    do_reset();
    step(4'b0110, 4'b0, 2'd1);
    step(4'b0000, 4'b0, 2'd1);
    step(4'b0000, 4'b0, 2'd1);
    checks++;
    if (bus8.onehot_err !== 1'b1 || bus8.last_ch !== 2'd1) begin
      errors++;
      $display("FAIL fault_set got err=%b last=%0d want 1/1", bus8.onehot_err, bus8.last_ch);
    end
    step(4'b0011, 4'b1111, 2'd0);
    checks++;
    if (bus8.onehot_err !== 1'b1) begin
      errors++;
      $display("FAIL fault_set_wins got %b want 1", bus8.onehot_err);
    end
    step(4'b0000, 4'b1111, 2'd0);
    checks++;
    if (bus8.onehot_err !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got %b want 0", bus8.onehot_err);
    end
    for (int s = 0; s < 4; s++) step(4'b0, 4'b0, 2'(s));
    step(4'b0, 4'b0, 2'd0);
    checks++;
    if (bus8.rd_count !== 8'd0 || bus8.sat !== 4'b0) begin
      errors++;
      $display("FAIL fault_counts got rd=%0d sat=%b want 0/0000", bus8.rd_count, bus8.sat);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 4'b0, 2'd0);
      step(4'b0000, 4'b0, 2'd0);
    end
    checks++;
    if (bus8.rd_count !== 8'd5 || bus8.last_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got rd=%0d lv=%b want 5/1", bus8.rd_count, bus8.last_valid);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus8.rd_count !== 8'd0 || bus8.last_valid !== 1'b0 || bus2.rd_count !== 2'd0) begin
      errors++;
      $display("FAIL async_now got rd=%0d lv=%b rd2=%0d want 0/0/0",
               bus8.rd_count, bus8.last_valid, bus2.rd_count);
    end
    @(negedge clk);
    rst = 1'b0;
    step(4'b0, 4'b0, 2'd0);
    checks++;
    if (bus8.rd_count !== 8'd0) begin
      errors++;
      $display("FAIL async_counter got %0d want 0", bus8.rd_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ch, c;
    int         r;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) ch = 4'(1 << r);
      else if (r == 9) ch = 4'($urandom_range(0, 15));
      else ch = 4'b0;
      c = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      step(ch, c, 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus8.ch_in  = 4'b0;
    bus8.clr    = 4'b0;
    bus8.rd_sel = 2'd0;
    model_reset();
    test_reset();
    test_counting();
    test_saturation();
    test_clr_collision();
    test_demux_fault();
    test_async_reset();
    test_back_to_back();
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
